key_counter_leds: RTL



---
 rtl/key_counter_leds.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/key_counter_leds.sv
// key_counter_leds
// ----------------
// Turns raw push-buttons into debounced one-cycle press pulses. The pulses
// drive a wrap-around up/down counter or a toggle register. The LED vector
// shows the state in one of four runtime modes.
//
// Ports
//   clk    in   1                         system clock
//   rst    in   1                         synchronous active-high reset
//   key    in   w_key                     raw keys: [0] inc, [1] dec,
//                                         [2] clear, [3] mode step
//   press  out  w_key                     registered one-cycle press pulses
//   mode   out  2                         0 binary, 1 one-hot,
//                                         2 thermometer, 3 toggle
//   count  out  $clog2(max_count+1)       counter value, range 0..max_count
//   led    out  w_led                     registered LED pattern
//
// Timing: a key level first sampled at edge E0 and held steady produces a
// press pulse in the cycle after edge E0 + debounce_cycles + 2. count,
// mode, the toggle register and led all update on the edge that ends that
// pulse cycle.

module key_counter_leds #(
    parameter int               w_key           = 4,
    parameter int               w_led           = 8,
    parameter int               max_count       = 8,
    parameter int               debounce_cycles = 500000,
    parameter logic             key_active_low  = 1'b0,
    parameter logic [w_led-1:0] toggle_mask     = 8'b0000_0111
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [w_key-1:0]               key,
    output logic [w_key-1:0]               press,
    output logic [1:0]                     mode,
    output logic [$clog2(max_count+1)-1:0] count,
    output logic [w_led-1:0]               led
);

    localparam int cw = $clog2(max_count + 1);
    localparam int dw = $clog2(debounce_cycles + 1);

    localparam logic [cw-1:0]    count_max = cw'(max_count);
    localparam logic [dw-1:0]    db_limit  = dw'(debounce_cycles);
    localparam logic [w_led-1:0] lsb_mask  = w_led'(1'b1);

    // Key conditioning: after this XOR, a level of 1 always means pressed.
    logic [w_key-1:0] key_level_s;
    logic [w_key-1:0] sync1_r;
    logic [w_key-1:0] sync2_r;
    logic [w_key-1:0] deb_r;
    logic [w_key-1:0] deb_next_s;
    logic [w_key-1:0] rise_s;
    logic [dw-1:0]    db_cnt_r      [w_key];
    logic [dw-1:0]    db_cnt_next_s [w_key];

    // Counter, mode and display state.
    logic [w_key-1:0] press_r;
    logic [1:0]       mode_r;
    logic [1:0]       mode_next_s;
    logic [cw-1:0]    count_r;
    logic [cw-1:0]    count_next_s;
    logic [w_led-1:0] t_r;
    logic [w_led-1:0] t_next_s;
    logic [w_led-1:0] led_r;
    logic [w_led-1:0] led_next_s;
    logic [w_led-1:0] led_bin_s;
    logic [w_led-1:0] led_onehot_s;
    logic [w_led-1:0] led_therm_s;
    logic [w_led+cw-1:0] bin_wide_s;

    assign key_level_s = key ^ {w_key{key_active_low}};

    // Two-flop synchronizer for the conditioned key levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {w_key{1'b0}};
            sync2_r <= {w_key{1'b0}};
        end else begin
            sync1_r <= key_level_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next state. The counter only runs while the synced level
    // disagrees with the accepted level. The new level is accepted on the
    // edge where the counter already holds debounce_cycles and the levels
    // still disagree.
    always_comb begin
        deb_next_s = deb_r;
        for (int i = 0; i < w_key; i++) begin
            db_cnt_next_s[i] = {dw{1'b0}};
            if (sync2_r[i] == deb_r[i]) begin
                db_cnt_next_s[i] = {dw{1'b0}};
            end else if (db_cnt_r[i] == db_limit) begin
                deb_next_s[i]    = sync2_r[i];
                db_cnt_next_s[i] = {dw{1'b0}};
            end else begin
                db_cnt_next_s[i] = db_cnt_r[i] + dw'(1'b1);
            end
        end
        rise_s = deb_next_s & ~deb_r;
    end

    // Debounce state and the registered press pulse (released to pressed only).
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_r   <= {w_key{1'b0}};
            press_r <= {w_key{1'b0}};
            for (int i = 0; i < w_key; i++) begin
                db_cnt_r[i] <= {dw{1'b0}};
            end
        end else begin
            deb_r   <= deb_next_s;
            press_r <= rise_s;
            for (int i = 0; i < w_key; i++) begin
                db_cnt_r[i] <= db_cnt_next_s[i];
            end
        end
    end

    // Counter/toggle/mode next state from this cycle's press pulses. Clear
    // wins. Inc and dec together cancel out. The current (old) mode decides
    // whether inc/dec act on the counter or on the toggle register. A mode
    // step combines with any of these.
    always_comb begin
        count_next_s = count_r;
        t_next_s     = t_r;
        mode_next_s  = press_r[3] ? (mode_r + 2'd1) : mode_r;
        if (press_r[2]) begin
            count_next_s = {cw{1'b0}};
            t_next_s     = {w_led{1'b0}};
        end else if (press_r[0] && press_r[1]) begin
            count_next_s = count_r;
            t_next_s     = t_r;
        end else if (press_r[0]) begin
            if (mode_r == 2'd3) begin
                t_next_s = t_r ^ toggle_mask;
            end else if (count_r == count_max) begin
                count_next_s = {cw{1'b0}};
            end else begin
                count_next_s = count_r + cw'(1'b1);
            end
        end else if (press_r[1]) begin
            if (mode_r == 2'd3) begin
                t_next_s = t_r ^ lsb_mask;
            end else if (count_r == {cw{1'b0}}) begin
                count_next_s = count_max;
            end else begin
                count_next_s = count_r - cw'(1'b1);
            end
        end else begin
            count_next_s = count_r;
            t_next_s     = t_r;
        end
    end

    // LED pattern from the next-state values, so led changes on the same
    // edge as count, mode and t.
    always_comb begin
        bin_wide_s = {{w_led{1'b0}}, count_next_s};
        led_bin_s  = bin_wide_s[w_led-1:0];
        for (int i = 0; i < w_led; i++) begin
            led_onehot_s[i] = (int'(count_next_s) == (i + 1));
            led_therm_s[i]  = (int'(count_next_s) > i);
        end
        case (mode_next_s)
            2'd0:    led_next_s = led_bin_s;
            2'd1:    led_next_s = led_onehot_s;
            2'd2:    led_next_s = led_therm_s;
            2'd3:    led_next_s = t_next_s;
            default: led_next_s = {w_led{1'b0}};
        endcase
    end

    // Counter, mode, toggle register and LED output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r  <= 2'd0;
            count_r <= {cw{1'b0}};
            t_r     <= {w_led{1'b0}};
            led_r   <= {w_led{1'b0}};
        end else begin
            mode_r  <= mode_next_s;
            count_r <= count_next_s;
            t_r     <= t_next_s;
            led_r   <= led_next_s;
        end
    end

    assign press = press_r;
    assign mode  = mode_r;
    assign count = count_r;
    assign led   = led_r;

endmodule
